// File: rtl/uvmt_cv32e40x_exceptions_tracker.sv
// Exceptions tracker: picks the winning synchronous exception at writeback,
// counts occurrences per cause and checks that the core traps with the
// matching mcause within MAX_LAT cycles.
module uvmt_cv32e40x_exceptions_tracker #(
    parameter int NUM_CAUSES = 8,
    parameter int CAUSE_W    = 6,
    parameter int CNT_W      = 16,
    parameter int MAX_LAT    = 8,
    localparam int IDX_W     = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1,
    localparam int TMR_W     = $clog2(MAX_LAT + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wb_valid_i,
    input  logic [NUM_CAUSES-1:0]         cause_vec_i,
    input  logic [NUM_CAUSES*CAUSE_W-1:0] cause_code_i,
    input  logic                          trap_taken_i,
    input  logic [CAUSE_W-1:0]            trap_cause_i,
    input  logic                          clr_cnt_i,
    output logic                          exc_valid_o,
    output logic [IDX_W-1:0]              exc_idx_o,
    output logic [CAUSE_W-1:0]            exc_code_o,
    output logic                          pending_o,
    output logic                          err_timeout_o,
    output logic                          err_cause_o,
    output logic                          err_spurious_o,
    output logic                          err_overlap_o,
    output logic [NUM_CAUSES*CNT_W-1:0]   cnt_o,
    output logic [CNT_W-1:0]              total_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                             state_q, state_d;
    logic [TMR_W-1:0]                   timer_q, timer_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [CAUSE_W-1:0]                 code_q, code_d;
    logic                               exc_valid_q, exc_valid_d;
    logic                               err_timeout_q, err_timeout_d;
    logic                               err_cause_q, err_cause_d;
    logic                               err_spurious_q, err_spurious_d;
    logic                               err_overlap_q, err_overlap_d;
    logic [NUM_CAUSES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]                   total_q, total_d;

    logic                               detect;
    logic [IDX_W-1:0]                   win_idx;
    logic [CAUSE_W-1:0]                 win_code;

    assign detect = wb_valid_i && (|cause_vec_i);

    // Fixed priority: scan downward so the lowest set index wins.
    always_comb begin
        win_idx  = '0;
        win_code = '0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (cause_vec_i[i]) begin
                win_idx  = IDX_W'(i);
                win_code = cause_code_i[i*CAUSE_W +: CAUSE_W];
            end
        end
    end

    // Expectation FSM, latency timer and error pulses.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        idx_d          = idx_q;
        code_d         = code_q;
        exc_valid_d    = 1'b0;
        err_timeout_d  = 1'b0;
        err_cause_d    = 1'b0;
        err_spurious_d = 1'b0;
        err_overlap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (detect) begin
                    exc_valid_d = 1'b1;
                    idx_d       = win_idx;
                    code_d      = win_code;
                    if (trap_taken_i) begin
                        err_cause_d = (trap_cause_i != win_code);
                    end else begin
                        state_d = WAIT;
                        timer_d = TMR_W'(1);
                    end
                end else if (trap_taken_i) begin
                    err_spurious_d = 1'b1;
                end
            end
            WAIT: begin
                if (trap_taken_i) begin
                    err_cause_d = (trap_cause_i != code_q);
                    if (detect) begin
                        // Back-to-back: the new exception becomes the expectation.
                        exc_valid_d = 1'b1;
                        idx_d       = win_idx;
                        code_d      = win_code;
                        timer_d     = TMR_W'(1);
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else begin
                    // Overlapping detection is counted but does not replace the expectation.
                    err_overlap_d = detect;
                    if (timer_q == TMR_W'(MAX_LAT)) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                        timer_d       = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Saturating per-cause and total counters; clear beats increment.
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        if (clr_cnt_i) begin
            cnt_d   = '0;
            total_d = '0;
        end else if (detect) begin
            if (cnt_q[win_idx] != {CNT_W{1'b1}}) cnt_d[win_idx] = cnt_q[win_idx] + CNT_W'(1);
            if (total_q != {CNT_W{1'b1}})        total_d        = total_q + CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            idx_q          <= '0;
            code_q         <= '0;
            exc_valid_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_cause_q    <= 1'b0;
            err_spurious_q <= 1'b0;
            err_overlap_q  <= 1'b0;
            cnt_q          <= '0;
            total_q        <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            idx_q          <= idx_d;
            code_q         <= code_d;
            exc_valid_q    <= exc_valid_d;
            err_timeout_q  <= err_timeout_d;
            err_cause_q    <= err_cause_d;
            err_spurious_q <= err_spurious_d;
            err_overlap_q  <= err_overlap_d;
            cnt_q          <= cnt_d;
            total_q        <= total_d;
        end
    end

    assign exc_valid_o    = exc_valid_q;
    assign exc_idx_o      = idx_q;
    assign exc_code_o     = code_q;
    assign pending_o      = (state_q == WAIT);
    assign err_timeout_o  = err_timeout_q;
    assign err_cause_o    = err_cause_q;
    assign err_spurious_o = err_spurious_q;
    assign err_overlap_o  = err_overlap_q;
    assign cnt_o          = cnt_q;
    assign total_o        = total_q;

endmodule
